inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Instruction queue between fetch and decode: a circular FIFO that buffers fetched instructions plus their branch-prediction metadata.
- Presents the head entry to decode as inst/pc/pc_next with iqueue_out_valid.
- Pops on decode acceptance; flushed entirely by jump_commit.
- Producer side of the interface decode consumes.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not to be overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- jump_commit  input  1  flush: discard all entries.
- enq_valid  input  1  fetch presents an instruction.
- enq_ready  output  1  queue can accept; equals !full.
- enq_inst  input  32  instruction word.
- enq_pc  input  32  instruction PC.
- enq_pc_next  input  32  fetch's next PC (predicted).
- enq_btb_addr  input  32  BTB target.
- enq_br_prediction  input  2  predictor counter value.
- enq_btb_valid  input  1  BTB hit.
- enq_predictor_valid  input  1  predictor entry valid.
- enq_predictor_index  input  8  predictor table index.
- deq_ready  input  1  decode/rename accepts head this cycle.
- iqueue_out_valid  output  1  head entry valid; equals !empty.
- inst, pc, pc_next  output  32 each  head entry fields.
- btb_addr  output  32  head field.
- br_prediction  output  2  head field.
- btb_valid_out, predictor_valid_out  output  1 each  head fields.
- predictor_index  output  8  head field.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Storage:
  - DEPTH-entry array of {inst, pc, pc_next, btb_addr, br_prediction, btb_valid, predictor_valid, predictor_index}.
  - Registers head, tail (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset (rst_n low, async):
  - head = tail = count = 0.
  - enq_ready = 1, iqueue_out_valid = 0.
  - All head-field outputs read 0 while empty; the array is not reset, so outputs are masked to 0 when empty.
- Enqueue: fires when enq_valid && enq_ready. Write the entry at tail; tail <= tail+1.
- Dequeue: fires when deq_ready && iqueue_out_valid. head <= head+1.
- deq_ready while empty has no effect.
- Outputs are show-ahead: combinational from the array at head, with no registered stage. Latency from enqueue to visible at the head is 1 cycle.
- count:
  - +1 on enqueue only, -1 on dequeue only.
  - Unchanged when both fire.
- Full (count==DEPTH):
  - enq_ready = 0; enq_valid is ignored.
  - A simultaneous dequeue does not raise enq_ready in the same cycle (no ready-through path).
  - enq_ready rises the cycle after count drops.
- Empty (count==0): a simultaneous enq/deq is impossible, since deq has no effect while empty (outside the bypass case in Optional Feature).
- Both fire with 0<count<DEPTH: both pointers advance; count is held.
- Wrap: the pointer after DEPTH-1 is 0. Data order is preserved across the wrap.
- Flush (jump_commit=1, synchronous):
  - Next edge: head = tail = count = 0.
  - Flush has priority over enqueue and dequeue in the same cycle; that cycle's enqueued instruction is dropped.
  - iqueue_out_valid = 0 from the cycle after flush.
  - During the flush cycle, outputs still reflect the pre-flush head; decode discards them, since it also sees jump_commit.
- Reset mid-operation: all state clears immediately; entries are lost.
- No other states. There is no FSM beyond the pointers and count.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and enq_valid && !jump_commit, iqueue_out_valid = 1 combinationally and the head outputs carry the enq_* fields in that same cycle (0-cycle latency).
  - If deq_ready is also 1, the instruction is consumed: no array write, pointers and count unchanged.
  - Otherwise it is written normally (count -> 1).
- Undefined:
  - Empty-queue enqueue becomes visible next cycle only.
  - iqueue_out_valid is strictly !empty.

Test Plan:
- Reset then idle -> enq_ready=1, iqueue_out_valid=0, count=0, inst=0.
- Enqueue PCs 0x1000,0x1004,0x1008 (inst 0x00000013) with deq_ready=0 -> count=3; head pc=0x1000; then deq_ready=1 for 3 cycles -> pc sequence 0x1000,0x1004,0x1008, then iqueue_out_valid=0.
- DEPTH=8: enqueue 8 entries with deq_ready=0 -> count=8, enq_ready=0; a 9th enqueue (pc 0x2020) is ignored. One dequeue plus a simultaneous enqueue attempt -> enqueue is not accepted, count=7; enq_ready=1 next cycle.
- Continuous enqueue/dequeue for 20 cycles starting with count=3 -> count stays 3; outputs follow strict PC order across the pointer wrap; br_prediction and predictor_index travel with their instruction.
- count=5 with jump_commit=1, enq_valid=1 and deq_ready=1 in the same cycle -> next cycle count=0, iqueue_out_valid=0; a later enqueue of pc 0x3000 appears as head.
- With INST_QUEUE_BYPASS_EN: empty queue, enq pc 0x4000 with deq_ready=1 -> same-cycle iqueue_out_valid=1, pc=0x4000, count stays 0. Without the macro: iqueue_out_valid=0 that cycle and pc=0x4000 valid next cycle.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of fetched instructions plus
// branch-prediction metadata, show-ahead head outputs. Optional macro: INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump_commit,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_pc_next,
  input  logic [31:0]      enq_btb_addr,
  input  logic [1:0]       enq_br_prediction,
  input  logic             enq_btb_valid,
  input  logic             enq_predictor_valid,
  input  logic [7:0]       enq_predictor_index,
  input  logic             deq_ready,
  output logic             iqueue_out_valid,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      pc_next,
  output logic [31:0]      btb_addr,
  output logic [1:0]       br_prediction,
  output logic             btb_valid_out,
  output logic             predictor_valid_out,
  output logic [7:0]       predictor_index,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] btb_addr;
    logic [1:0]  br_prediction;
    logic        btb_valid;
    logic        predictor_valid;
    logic [7:0]  predictor_index;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           enq_entry, out_entry;
  logic             empty, full, enq_fire, deq_fire, byp_valid, byp_consume;

  assign enq_entry = '{inst:            enq_inst,
                       pc:              enq_pc,
                       pc_next:         enq_pc_next,
                       btb_addr:        enq_btb_addr,
                       br_prediction:   enq_br_prediction,
                       btb_valid:       enq_btb_valid,
                       predictor_valid: enq_predictor_valid,
                       predictor_index: enq_predictor_index};

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
  assign byp_valid = empty && enq_valid && !jump_commit;
`else
  assign byp_valid = 1'b0;
`endif

  // A bypassed instruction taken by decode in the same cycle never touches the array.
  assign byp_consume = byp_valid && deq_ready;
  assign enq_fire    = enq_valid && !full && !byp_consume;
  assign deq_fire    = deq_ready && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (jump_commit) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the head outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (enq_fire && !jump_commit) mem_q[tail_q] <= enq_entry;
  end

  always_comb begin
    out_entry = '0;
    if (!empty)         out_entry = mem_q[head_q];
    else if (byp_valid) out_entry = enq_entry;
  end

  assign enq_ready           = !full;
  assign iqueue_out_valid    = !empty || byp_valid;
  assign inst                = out_entry.inst;
  assign pc                  = out_entry.pc;
  assign pc_next             = out_entry.pc_next;
  assign btb_addr            = out_entry.btb_addr;
  assign br_prediction       = out_entry.br_prediction;
  assign btb_valid_out       = out_entry.btb_valid;
  assign predictor_valid_out = out_entry.predictor_valid;
  assign predictor_index     = out_entry.predictor_index;
  assign count               = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8); expected head contents come from a PC scoreboard.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_commit;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_inst, enq_pc, enq_pc_next, enq_btb_addr;
  logic [1:0]  enq_br_prediction;
  logic        enq_btb_valid, enq_predictor_valid;
  logic [7:0]  enq_predictor_index;
  logic        deq_ready;
  logic        iqueue_out_valid;
  logic [31:0] inst, pc, pc_next, btb_addr;
  logic [1:0]  br_prediction;
  logic        btb_valid_out, predictor_valid_out;
  logic [7:0]  predictor_index;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .jump_commit(jump_commit),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_inst(enq_inst), .enq_pc(enq_pc), .enq_pc_next(enq_pc_next),
    .enq_btb_addr(enq_btb_addr), .enq_br_prediction(enq_br_prediction),
    .enq_btb_valid(enq_btb_valid), .enq_predictor_valid(enq_predictor_valid),
    .enq_predictor_index(enq_predictor_index), .deq_ready(deq_ready),
    .iqueue_out_valid(iqueue_out_valid), .inst(inst), .pc(pc), .pc_next(pc_next),
    .btb_addr(btb_addr), .br_prediction(br_prediction), .btb_valid_out(btb_valid_out),
    .predictor_valid_out(predictor_valid_out), .predictor_index(predictor_index),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every metadata field is a distinct function of the PC so mix-ups between entries show.
  task automatic set_enq(input logic v, input logic [31:0] p, input logic [31:0] ins);
    enq_valid           = v;
    enq_pc              = p;
    enq_inst            = ins;
    enq_pc_next         = p + 32'd4;
    enq_btb_addr        = p + 32'h100;
    enq_br_prediction   = p[3:2];
    enq_btb_valid       = p[2];
    enq_predictor_valid = p[3];
    enq_predictor_index = p[11:4] ^ 8'h5a;
  endtask

  task automatic check_head(input string tag);
    logic [31:0] p;
    if (exp_pc_q.size() == 0) begin
      chk({tag, ".valid"}, {31'b0, iqueue_out_valid}, 32'd0);
      chk({tag, ".pc0"}, pc, 32'd0);
    end else begin
      p = exp_pc_q[0];
      chk({tag, ".valid"}, {31'b0, iqueue_out_valid}, 32'd1);
      chk({tag, ".pc"}, pc, p);
      chk({tag, ".inst"}, inst, exp_inst_q[0]);
      chk({tag, ".pc_next"}, pc_next, p + 32'd4);
      chk({tag, ".btb_addr"}, btb_addr, p + 32'h100);
      chk({tag, ".br_pred"}, {30'b0, br_prediction}, {30'b0, p[3:2]});
      chk({tag, ".btb_v"}, {31'b0, btb_valid_out}, {31'b0, p[2]});
      chk({tag, ".pred_v"}, {31'b0, predictor_valid_out}, {31'b0, p[3]});
      chk({tag, ".pred_idx"}, {24'b0, predictor_index}, {24'b0, p[11:4] ^ 8'h5a});
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] ins);
    exp_pc_q.push_back(p);
    exp_inst_q.push_back(ins);
  endtask

  task automatic pop;
    void'(exp_pc_q.pop_front());
    void'(exp_inst_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    jump_commit = 1'b0;
    deq_ready = 1'b0;
    set_enq(1'b0, 32'd0, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    #1;
    chk("reset.enq_ready", {31'b0, enq_ready}, 32'd1);
    chk("reset.count", {28'b0, count}, 32'd0);
    chk("reset.inst", inst, 32'd0);
    check_head("reset");

    // Three enqueues then drain in order.
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h1000 + 32'(4 * i), 32'h13);
      tick;
      push(32'h1000 + 32'(4 * i), 32'h13);
    end
    set_enq(1'b0, 32'd0, 32'd0);
    #1;
    chk("three.count", {28'b0, count}, 32'd3);
    check_head("three.head");
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain.pc", pc, 32'h1000 + 32'(4 * i));
      tick;
      pop;
    end
    deq_ready = 1'b0;
    #1;
    chk("drain.count", {28'b0, count}, 32'd0);
    check_head("drain.empty");

    // Fill to DEPTH, 9th enqueue ignored, no ready-through on simultaneous dequeue.
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b1, 32'h2000 + 32'(4 * i), 32'hA000 + 32'(i));
      tick;
      push(32'h2000 + 32'(4 * i), 32'hA000 + 32'(i));
    end
    #1;
    chk("full.count", {28'b0, count}, 32'd8);
    chk("full.enq_ready", {31'b0, enq_ready}, 32'd0);
    set_enq(1'b1, 32'h2020, 32'hDEAD);
    tick;
    chk("ninth.count", {28'b0, count}, 32'd8);
    check_head("ninth.head");
    deq_ready = 1'b1;
    #1;
    chk("fulldeq.enq_ready", {31'b0, enq_ready}, 32'd0);
    tick;
    pop;
    set_enq(1'b0, 32'd0, 32'd0);
    deq_ready = 1'b0;
    #1;
    chk("fulldeq.count", {28'b0, count}, 32'd7);
    chk("fulldeq.enq_ready_next", {31'b0, enq_ready}, 32'd1);
    check_head("fulldeq.head");

    // Drain four more so three remain, head near the wrap point.
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_head("part.head");
      tick;
      pop;
    end
    deq_ready = 1'b0;
    #1;
    chk("part.count", {28'b0, count}, 32'd3);

    // Continuous streaming across the pointer wrap: occupancy holds at 3.
    deq_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_enq(1'b1, 32'h5000 + 32'(4 * k), 32'hB000 + 32'(k));
      #1;
      chk("stream.count", {28'b0, count}, 32'd3);
      check_head("stream.head");
      tick;
      pop;
      push(32'h5000 + 32'(4 * k), 32'hB000 + 32'(k));
    end
    deq_ready = 1'b0;
    set_enq(1'b0, 32'd0, 32'd0);
    #1;
    chk("stream.count_end", {28'b0, count}, 32'd3);

    // Bring occupancy to 5, then flush together with enqueue and dequeue.
    for (int i = 0; i < 2; i++) begin
      set_enq(1'b1, 32'h7000 + 32'(4 * i), 32'hC000 + 32'(i));
      tick;
      push(32'h7000 + 32'(4 * i), 32'hC000 + 32'(i));
    end
    set_enq(1'b0, 32'd0, 32'd0);
    #1;
    chk("preflush.count", {28'b0, count}, 32'd5);
    jump_commit = 1'b1;
    deq_ready = 1'b1;
    set_enq(1'b1, 32'h6000, 32'hEEEE);
    #1;
    check_head("flush.prehead");
    tick;
    exp_pc_q.delete();
    exp_inst_q.delete();
    jump_commit = 1'b0;
    deq_ready = 1'b0;
    set_enq(1'b0, 32'd0, 32'd0);
    #1;
    chk("flush.count", {28'b0, count}, 32'd0);
    check_head("flush.empty");
    set_enq(1'b1, 32'h3000, 32'h33);
    tick;
    push(32'h3000, 32'h33);
    set_enq(1'b0, 32'd0, 32'd0);
    #1;
    chk("postflush.count", {28'b0, count}, 32'd1);
    check_head("postflush.head");
    deq_ready = 1'b1;
    tick;
    pop;
    deq_ready = 1'b0;
    #1;
    chk("postflush.drained", {28'b0, count}, 32'd0);

    // Empty-queue enqueue with decode ready.
    set_enq(1'b1, 32'h4000, 32'h44);
    deq_ready = 1'b1;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("bypass.valid", {31'b0, iqueue_out_valid}, 32'd1);
    chk("bypass.pc", pc, 32'h4000);
    chk("bypass.count", {28'b0, count}, 32'd0);
    tick;
    set_enq(1'b0, 32'd0, 32'd0);
    deq_ready = 1'b0;
    #1;
    chk("bypass.count_after", {28'b0, count}, 32'd0);
    check_head("bypass.after");
`else
    chk("nobypass.valid", {31'b0, iqueue_out_valid}, 32'd0);
    chk("nobypass.pc", pc, 32'd0);
    tick;
    push(32'h4000, 32'h44);
    set_enq(1'b0, 32'd0, 32'd0);
    deq_ready = 1'b0;
    #1;
    chk("nobypass.count", {28'b0, count}, 32'd1);
    check_head("nobypass.next");
`endif

    // Asynchronous reset in the middle of operation.
    set_enq(1'b1, 32'h8000, 32'h88);
    tick;
    set_enq(1'b0, 32'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_pc_q.delete();
    exp_inst_q.delete();
    chk("midreset.count", {28'b0, count}, 32'd0);
    chk("midreset.enq_ready", {31'b0, enq_ready}, 32'd1);
    check_head("midreset");
    tick;
    rst_n = 1'b1;
    #1;
    chk("midreset.count_after", {28'b0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
